// File: rtl/stage_three_if.sv
// Operand-stage bus: decode-side S1 fields, write-back port, and the registered S2 fields toward the ALU.
interface stage_three_if;
  logic [4:0]  S1_RD1;
  logic [4:0]  S1_RD2;
  logic [15:0] S1_IMM;
  logic        S1_DataSource;
  logic [2:0]  S1_ALUOP;
  logic [4:0]  S1_WS;
  logic        S1_WE;
  logic [4:0]  WB_WA;
  logic [31:0] WB_WD;
  logic        WB_WE;
  logic [31:0] S2_OpA;
  logic [31:0] S2_OpB;
  logic [2:0]  S2_ALUOP;
  logic [4:0]  S2_WS;
  logic        S2_WE;

  // No valid/ready: the stage captures S1_* on every rising edge and presents
  // the result on S2_* one cycle later; WB_* is sampled on the same edge.
  modport master (
    output S1_RD1, S1_RD2, S1_IMM, S1_DataSource, S1_ALUOP, S1_WS, S1_WE,
    output WB_WA, WB_WD, WB_WE,
    input  S2_OpA, S2_OpB, S2_ALUOP, S2_WS, S2_WE
  );

  modport slave (
    input  S1_RD1, S1_RD2, S1_IMM, S1_DataSource, S1_ALUOP, S1_WS, S1_WE,
    input  WB_WA, WB_WD, WB_WE,
    output S2_OpA, S2_OpB, S2_ALUOP, S2_WS, S2_WE
  );
endinterface

// File: rtl/stage_three.sv
// Register-read/operand stage: 32x32 register file, immediate sign-extension, operand B select.
// Optional macro STAGE_THREE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module stage_three (
    input logic         clk,
    input logic         reset,
    stage_three_if.slave bus
);

    logic [31:0] regs_q [32];
    logic [31:0] rd_a, rd_b, imm_sext;
    logic [31:0] opa_d, opa_q, opb_d, opb_q;
    logic [2:0]  aluop_q;
    logic [4:0]  ws_q;
    logic        we_q;
    logic        wb_write;

    assign wb_write = bus.WB_WE && (bus.WB_WA != 5'd0);
    assign imm_sext = {{16{bus.S1_IMM[15]}}, bus.S1_IMM};

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_write) begin
            regs_q[bus.WB_WA] <= bus.WB_WD;
        end
    end

    always_comb begin
        rd_a = (bus.S1_RD1 == 5'd0) ? 32'd0 : regs_q[bus.S1_RD1];
        rd_b = (bus.S1_RD2 == 5'd0) ? 32'd0 : regs_q[bus.S1_RD2];
`ifdef STAGE_THREE_BYPASS_EN
        // wb_write already excludes address 0, so r0 is never forwarded.
        if (wb_write && (bus.WB_WA == bus.S1_RD1)) rd_a = bus.WB_WD;
        if (wb_write && (bus.WB_WA == bus.S1_RD2)) rd_b = bus.WB_WD;
`endif
        opa_d = rd_a;
        opb_d = bus.S1_DataSource ? imm_sext : rd_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q   <= '0;
            opb_q   <= '0;
            aluop_q <= '0;
            ws_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            aluop_q <= bus.S1_ALUOP;
            ws_q    <= bus.S1_WS;
            we_q    <= bus.S1_WE;
        end
    end

    assign bus.S2_OpA   = opa_q;
    assign bus.S2_OpB   = opb_q;
    assign bus.S2_ALUOP = aluop_q;
    assign bus.S2_WS    = ws_q;
    assign bus.S2_WE    = we_q;

endmodule

// File: tb/tb_stage_three.sv
// Directed bench for stage_three: driver pushes hand-computed results, monitor pops and compares.
module tb_stage_three;
  logic clk;
  logic reset;
  logic in_valid;
  logic out_valid;
  int   n_checks;
  int   n_errors;

`ifdef STAGE_THREE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // {opa[31:0], opb[31:0], aluop[2:0], ws[4:0], we}
  logic [72:0] exp_q[$];

  stage_three_if bus ();

  stage_three dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= in_valid;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_opa"},   bus.S2_OpA, 32'd0);
    cmp({tag, "_opb"},   bus.S2_OpB, 32'd0);
    cmp({tag, "_aluop"}, {29'd0, bus.S2_ALUOP}, 32'd0);
    cmp({tag, "_ws"},    {27'd0, bus.S2_WS}, 32'd0);
    cmp({tag, "_we"},    {31'd0, bus.S2_WE}, 32'd0);
  endtask

  // driver
  task automatic drive(input bit chk, input logic [4:0] rd1, input logic [4:0] rd2,
                       input logic [15:0] imm, input logic ds, input logic [2:0] aluop,
                       input logic [4:0] ws, input logic we, input logic wbwe,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] exp_a, input logic [31:0] exp_b);
    @(negedge clk);
    bus.S1_RD1 = rd1;  bus.S1_RD2 = rd2;  bus.S1_IMM = imm;
    bus.S1_DataSource = ds;  bus.S1_ALUOP = aluop;  bus.S1_WS = ws;  bus.S1_WE = we;
    bus.WB_WE = wbwe;  bus.WB_WA = wa;  bus.WB_WD = wd;
    in_valid = chk;
    if (chk) exp_q.push_back({exp_a, exp_b, aluop, ws, we});
  endtask

  task automatic wb_write(input logic [4:0] wa, input logic [31:0] wd);
    drive(1'b0, 5'd0, 5'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, wa, wd, 32'd0, 32'd0);
  endtask

  // Asserts reset between edges with a nonzero instruction in flight and a
  // write-back attempt held during reset.
  task automatic mid_reset();
    @(negedge clk);
    in_valid = 1'b0;
    bus.S1_RD1 = 5'd5;  bus.S1_ALUOP = 3'd6;  bus.S1_WS = 5'd9;  bus.S1_WE = 1'b1;
    bus.WB_WE = 1'b1;  bus.WB_WA = 5'd5;  bus.WB_WD = 32'hCAFE_F00D;
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    exp_q.delete();
    @(posedge clk);
    #1 check_zero("rst_held");
    @(negedge clk);
    reset = 1'b0;
    bus.WB_WE = 1'b0;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (out_valid && !reset) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: output with no expected entry");
      end else begin
        logic [72:0] e;
        e = exp_q.pop_front();
        cmp("opa",   bus.S2_OpA, e[72:41]);
        cmp("opb",   bus.S2_OpB, e[40:9]);
        cmp("aluop", {29'd0, bus.S2_ALUOP}, {29'd0, e[8:6]});
        cmp("ws",    {27'd0, bus.S2_WS}, {27'd0, e[5:1]});
        cmp("we",    {31'd0, bus.S2_WE}, {31'd0, e[0]});
      end
    end
  end

  logic [4:0]  v_rd1 [10];
  logic [4:0]  v_rd2 [10];
  logic [15:0] v_imm [10];
  logic        v_ds  [10];
  logic [31:0] v_a   [10];
  logic [31:0] v_b   [10];

  initial begin
    n_checks = 0;
    n_errors = 0;
    in_valid = 1'b0;
    reset = 1'b0;
    bus.S1_RD1 = '0;  bus.S1_RD2 = '0;  bus.S1_IMM = '0;  bus.S1_DataSource = 1'b0;
    bus.S1_ALUOP = '0;  bus.S1_WS = '0;  bus.S1_WE = 1'b0;
    bus.WB_WA = '0;  bus.WB_WD = '0;  bus.WB_WE = 1'b0;

    #3 reset = 1'b1;
    #1 check_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reg 5 written, readable next cycle
    wb_write(5'd5, 32'h1234_5678);
    drive(1'b1, 5'd5, 5'd5, 16'd0, 1'b0, 3'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'd0,
          32'h1234_5678, 32'h1234_5678);
    // reset wipes the register file
    mid_reset();
    drive(1'b1, 5'd5, 5'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);

    // write/read
    wb_write(5'd3, 32'hDEAD_BEEF);
    drive(1'b1, 5'd3, 5'd3, 16'd0, 1'b0, 3'd2, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0,
          32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // register 0: same-cycle write to r0 never forwarded, never stored
    drive(1'b1, 5'd0, 5'd0, 16'd0, 1'b0, 3'd0, 5'd1, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF,
          32'd0, 32'd0);
    drive(1'b1, 5'd0, 5'd3, 16'd0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 5'd0, 32'd0,
          32'd0, 32'hDEAD_BEEF);

    // immediates and pass-through fields
    drive(1'b1, 5'd3, 5'd0, 16'h8001, 1'b1, 3'b101, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0,
          32'hDEAD_BEEF, 32'hFFFF_8001);
    drive(1'b1, 5'd0, 5'd3, 16'h0010, 1'b1, 3'b101, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0,
          32'd0, 32'h0000_0010);
    drive(1'b1, 5'd0, 5'd0, 16'h7FFF, 1'b1, 3'b111, 5'd31, 1'b0, 1'b0, 5'd0, 32'd0,
          32'd0, 32'h0000_7FFF);
    drive(1'b1, 5'd0, 5'd0, 16'h8000, 1'b1, 3'b010, 5'd16, 1'b1, 1'b0, 5'd0, 32'd0,
          32'd0, 32'hFFFF_8000);

    // same-cycle hazard on reg 4
    wb_write(5'd4, 32'h1);
    drive(1'b1, 5'd4, 5'd4, 16'd0, 1'b0, 3'd3, 5'd4, 1'b1, 1'b1, 5'd4, 32'h2,
          BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1);
    drive(1'b1, 5'd4, 5'd4, 16'd0, 1'b0, 3'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0,
          32'h2, 32'h2);

    // back-to-back stream; reg 10 is written during vector 0 (not read there)
    // state: r3=DEADBEEF, r4=2, r5=0, r10=A5A5A5A5 from vector 1 onwards
    v_rd1 = '{5'd3, 5'd10, 5'd4, 5'd0, 5'd3, 5'd5, 5'd10, 5'd4, 5'd0, 5'd3};
    v_rd2 = '{5'd4, 5'd3, 5'd10, 5'd3, 5'd0, 5'd5, 5'd10, 5'd4, 5'd4, 5'd10};
    v_imm = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h1234,
              16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0001};
    v_ds  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    v_a   = '{32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h2, 32'h0, 32'hDEAD_BEEF,
              32'h0, 32'hA5A5_A5A5, 32'h2, 32'h0, 32'hDEAD_BEEF};
    v_b   = '{32'h2, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h0000_1234,
              32'h0, 32'hA5A5_A5A5, 32'hFFFF_8000, 32'h2, 32'h0000_0001};
    for (int i = 0; i < 10; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      drive(1'b1, v_rd1[i], v_rd2[i], v_imm[i], v_ds[i], iv[2:0], 5'(i + 1), iv[0],
            (i == 0), 5'd10, 32'hA5A5_A5A5, v_a[i], v_b[i]);
    end

    @(negedge clk);
    in_valid = 1'b0;
    bus.WB_WE = 1'b0;
    for (int c = 0; c < 5 && exp_q.size() != 0; c++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
